// File: rtl/dff_univ_reg.sv
// Universal WIDTH-bit register: hold, shift left/right, parallel load, with
// synchronous clear/preset (clear wins, flagged). Optional parity output under DFF_UNIV_REG_PARITY_EN.
module dff_univ_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr_n,
    input  logic             pre_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_l,
    output logic             sout_r,
`ifdef DFF_UNIV_REG_PARITY_EN
    output logic             par,
`endif
    output logic             conflict
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shl_w, shr_w;
    logic             conflict_q, conflict_d;

    // A 1-bit register shifts by replacing its only bit with the serial input.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_w = sin_r;
            assign shr_w = sin_l;
        end else begin : g_wn
            assign shl_w = {q_q[WIDTH-2:0], sin_r};
            assign shr_w = {sin_l, q_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_d        = q_q;
        conflict_d = 1'b0;
        if (!sclr_n) begin
            q_d        = RESET_VAL;
            conflict_d = ~pre_n;
        end else if (!pre_n) begin
            q_d = PRESET_VAL;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: q_d = q_q;
                MODE_SHL:  q_d = shl_w;
                MODE_SHR:  q_d = shr_w;
                MODE_LOAD: q_d = d;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q        <= RESET_VAL;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

`ifdef DFF_UNIV_REG_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            par_q <= ^RESET_VAL;
        end else begin
            par_q <= ^q_d;
        end
    end

    assign par = par_q;
`endif

    assign q        = q_q;
    assign qn       = ~q_q;
    assign sout_l   = q_q[WIDTH-1];
    assign sout_r   = q_q[0];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_dff_univ_reg.sv
// Randomised self-checking bench for dff_univ_reg (WIDTH=8) against an
// arithmetic reference model; also covers parity when DFF_UNIV_REG_PARITY_EN is defined.
module tb_dff_univ_reg;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             clr;
    logic             sclr_n;
    logic             pre_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             sout_l;
    logic             sout_r;
    logic             conflict;
`ifdef DFF_UNIV_REG_PARITY_EN
    logic             par;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference state: the register value as a plain integer 0..255.
    int m_q    = 0;
    int m_conf = 0;

    always #5 clk = ~clk;

    dff_univ_reg #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .sclr_n   (sclr_n),
        .pre_n    (pre_n),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .q        (q),
        .qn       (qn),
        .sout_l   (sout_l),
        .sout_r   (sout_r),
`ifdef DFF_UNIV_REG_PARITY_EN
        .par      (par),
`endif
        .conflict (conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q"},        {24'd0, q},        m_q);
        check({tag, ".qn"},       {24'd0, qn},       255 - m_q);
        check({tag, ".sout_l"},   {31'd0, sout_l},   m_q / 128);
        check({tag, ".sout_r"},   {31'd0, sout_r},   m_q % 2);
        check({tag, ".conflict"}, {31'd0, conflict}, m_conf);
`ifdef DFF_UNIV_REG_PARITY_EN
        check({tag, ".par"},      {31'd0, par},      $countones(m_q) % 2);
`endif
    endtask

    // Apply one clock edge with the currently driven inputs, advance the model, check.
    task automatic tick(input string tag);
        if (!sclr_n) begin
            m_q    = 0;
            m_conf = pre_n ? 0 : 1;
        end else begin
            m_conf = 0;
            if (!pre_n) begin
                m_q = 255;
            end else if (en) begin
                case (mode)
                    2'd1:    m_q = (m_q * 2 + int'(sin_r)) % 256;
                    2'd2:    m_q = m_q / 2 + 128 * int'(sin_l);
                    2'd3:    m_q = int'(d);
                    default: m_q = m_q;
                endcase
            end
        end
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d %s: sclr_n=%b pre_n=%b en=%b mode=%0d d=%h sin_r=%b sin_l=%b -> q=%h conflict=%b",
                 n_txn, tag, sclr_n, pre_n, en, mode, d, sin_r, sin_l, q, conflict);
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        clr = 1'b0;
        #1;
        m_q    = 0;
        m_conf = 0;
        $display("txn %0d %s: async clr -> q=%h conflict=%b", n_txn, tag, q, conflict);
        check_outputs(tag);
        #1;
        clr = 1'b1;
    endtask

    task automatic set_op(input logic e, input logic [1:0] m);
        sclr_n = 1'b1;
        pre_n  = 1'b1;
        en     = e;
        mode   = m;
    endtask

    initial begin
        clr = 1'b0; sclr_n = 1'b1; pre_n = 1'b1; en = 1'b0;
        mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0;
        #12;
        check_outputs("reset");
        clr = 1'b1;
        #1;

        // Load A5, then async clear mid-cycle.
        set_op(1'b1, 2'b11); d = 8'hA5;
        tick("load_a5");
        async_reset("clr_mid");

        // Load 3C then shift left twice with sin_r=1: 79, F3.
        set_op(1'b1, 2'b11); d = 8'h3C;
        tick("load_3c");
        mode = 2'b01; sin_r = 1'b1;
        tick("shl_1");
        tick("shl_2");

        // Load 81, shift right with sin_l=0 -> 40.
        mode = 2'b11; d = 8'h81;
        tick("load_81");
        check("sout_r_pre", {31'd0, sout_r}, 1);
        mode = 2'b10; sin_l = 1'b0;
        tick("shr_1");

        // Preset overrides en=0, then clear.
        set_op(1'b0, 2'b00); pre_n = 1'b0;
        tick("preset");
        pre_n = 1'b1; sclr_n = 1'b0;
        tick("sclear");

        // Simultaneous clear/preset pulses conflict for one cycle.
        set_op(1'b1, 2'b11); d = 8'h5A;
        tick("load_5a");
        sclr_n = 1'b0; pre_n = 1'b0;
        tick("conflict");
        set_op(1'b0, 2'b11);
        tick("conflict_end");

`ifdef DFF_UNIV_REG_PARITY_EN
        set_op(1'b1, 2'b11); d = 8'h07;
        tick("par_07");
        d = 8'h03;
        tick("par_03");
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            sclr_n = ($urandom_range(0, 9) != 0);
            pre_n  = ($urandom_range(0, 9) != 0);
            en     = ($urandom_range(0, 3) != 0);
            mode   = 2'($urandom_range(0, 3));
            d      = 8'($urandom);
            sin_r  = 1'($urandom);
            sin_l  = 1'($urandom);
            tick("rand");
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rand_clr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
